// File: rtl/vect_pkg.sv
// Shared encodings for the multi-cycle vector execute stage.
// Contents: ALU operation encodings, op2 operand-select encodings and the
// sequencer state type. Used by exec_vect_seq and vect_lane_alu.
package vect_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_MUL   = 4'd7,
        ALU_PASSB = 4'd8,
        ALU_MINU  = 4'd9
    } alu_op_e;

    // Index is {fb, imm_src}
    typedef enum logic [1:0] {
        OP2_RD2  = 2'b00,
        OP2_IMM  = 2'b01,
        OP2_FWD  = 2'b10,
        OP2_ZERO = 2'b11
    } op2_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/vect_lane_alu.sv
// One lane of the vector ALU, purely combinational.
// Build option: EXEC_VECT_SAT_EN makes add/sub saturate unsigned
// (add clamps to all-ones, sub clamps to zero); otherwise they wrap.
// Ports:
//   i_a, i_b  N-bit lane operands
//   i_op      4-bit operation select (codes 10..15 give zero)
//   o_y       N-bit lane result
module vect_lane_alu
    import vect_pkg::*;
#(
    parameter int N = 24
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [3:0]   i_op,
    output logic [N-1:0] o_y
);

    logic [N-1:0] w_add;
    logic [N-1:0] w_sub;
    logic [N-1:0] w_prod;
    logic [4:0]   w_shamt;
    logic         w_sh_ovf;

`ifdef EXEC_VECT_SAT_EN
    logic         w_carry;
    logic         w_borrow;
    logic [N-1:0] w_add_raw;
    logic [N-1:0] w_sub_raw;

    assign {w_carry, w_add_raw}  = {1'b0, i_a} + {1'b0, i_b};
    assign {w_borrow, w_sub_raw} = {1'b0, i_a} - {1'b0, i_b};
    assign w_add = w_carry  ? '1 : w_add_raw;
    assign w_sub = w_borrow ? '0 : w_sub_raw;
`else
    assign w_add = i_a + i_b;
    assign w_sub = i_a - i_b;
`endif

    assign w_prod   = i_a * i_b;
    // Only b[4:0] is the shift amount; amounts past the lane width flush to 0
    assign w_shamt  = i_b[4:0];
    assign w_sh_ovf = ({27'd0, w_shamt} >= 32'(N));

    always_comb begin
        o_y = '0;
        case (i_op)
            ALU_ADD:   o_y = w_add;
            ALU_SUB:   o_y = w_sub;
            ALU_AND:   o_y = i_a & i_b;
            ALU_OR:    o_y = i_a | i_b;
            ALU_XOR:   o_y = i_a ^ i_b;
            ALU_SLL:   o_y = w_sh_ovf ? '0 : (i_a << w_shamt);
            ALU_SRL:   o_y = w_sh_ovf ? '0 : (i_a >> w_shamt);
            ALU_MUL:   o_y = w_prod;
            ALU_PASSB: o_y = i_b;
            ALU_MINU:  o_y = (i_a < i_b) ? i_a : i_b;
            default:   o_y = '0;
        endcase
    end

endmodule

// File: rtl/exec_vect_seq.sv
// Multi-cycle vector execute stage: M lanes of N bits, P lanes per cycle.
// Operands are selected and captured on a valid/ready accept, then a
// lane-group sequencer writes P lanes of the result per cycle; the
// finished result is offered with out_valid/out_ready.
// Build option: EXEC_VECT_SAT_EN (saturating add/sub, see vect_lane_alu).
// Ports:
//   clk, rst_n              clock, async active-low reset
//   flush                   synchronous abort to IDLE
//   in_valid / in_ready     request handshake
//   rd1..rd3, forward1..3   M*N operand buses, lane i at [i*N +: N]
//   imm                     N-bit immediate broadcast to all lanes
//   alu_control, imm_src, fa, fb, fc   operation / operand selects
//   out_valid / out_ready   result handshake
//   result, rd3_out         registered result and third operand
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request
// BUSY  | writing lane group grp into result each cycle
// DONE  | out_valid=1, outputs held until out_ready
module exec_vect_seq
    import vect_pkg::*;
#(
    parameter int N = 24,
    parameter int M = 6,
    parameter int P = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M*N-1:0] rd1,
    input  logic [M*N-1:0] rd2,
    input  logic [M*N-1:0] rd3,
    input  logic [M*N-1:0] forward1,
    input  logic [M*N-1:0] forward2,
    input  logic [M*N-1:0] forward3,
    input  logic [N-1:0]   imm,
    input  logic [3:0]     alu_control,
    input  logic           imm_src,
    input  logic           fa,
    input  logic           fb,
    input  logic           fc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M*N-1:0] result,
    output logic [M*N-1:0] rd3_out
);

    localparam int G  = M / P;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    if (M % P != 0) begin : g_bad_p
        $error("exec_vect_seq: M must be a multiple of P");
    end

    logic [M*N-1:0] w_op1;
    logic [M*N-1:0] w_op2;
    logic [M*N-1:0] w_op3;

    state_e         r_state;
    logic [GW-1:0]  r_grp;
    logic [M*N-1:0] r_op1;
    logic [M*N-1:0] r_op2;
    logic [3:0]     r_alu;
    logic [M*N-1:0] r_result;
    logic [M*N-1:0] r_rd3;
    logic           r_out_valid;
    logic           r_in_ready;

    logic [P*N-1:0] w_grp_a;
    logic [P*N-1:0] w_grp_b;
    logic [P*N-1:0] w_grp_y;
    logic           w_last;

    assign w_op1 = fa ? forward1 : rd1;
    assign w_op3 = fc ? forward3 : rd3;

    always_comb begin
        w_op2 = '0;
        case (op2_sel_e'({fb, imm_src}))
            OP2_RD2:  w_op2 = rd2;
            OP2_IMM:  w_op2 = {M{imm}};
            OP2_FWD:  w_op2 = forward2;
            OP2_ZERO: w_op2 = '0;
            default:  w_op2 = '0;
        endcase
    end

    assign w_grp_a = r_op1[r_grp*(P*N) +: P*N];
    assign w_grp_b = r_op2[r_grp*(P*N) +: P*N];
    assign w_last  = (r_grp == GW'(G - 1));

    for (genvar j = 0; j < P; j++) begin : g_lane
        vect_lane_alu #(.N(N)) u_alu (
            .i_a  (w_grp_a[j*N +: N]),
            .i_b  (w_grp_b[j*N +: N]),
            .i_op (r_alu),
            .o_y  (w_grp_y[j*N +: N])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_grp       <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_alu       <= '0;
            r_result    <= '0;
            r_rd3       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            // result and rd3_out deliberately keep their stale contents
            r_state     <= ST_IDLE;
            r_grp       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op1      <= w_op1;
                        r_op2      <= w_op2;
                        r_rd3      <= w_op3;
                        r_alu      <= alu_control;
                        r_grp      <= '0;
                        r_state    <= ST_BUSY;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    r_result[r_grp*(P*N) +: P*N] <= w_grp_y;
                    if (w_last) begin
                        r_grp       <= '0;
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_grp <= r_grp + GW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign rd3_out   = r_rd3;

endmodule

// File: tb/tb_exec_vect_seq.sv
// Testbench for exec_vect_seq (defaults N=24, M=6, P=2): a table of
// directed vectors, hand-written multi-cycle sequences (hold, reset,
// flush) and randomized requests checked against a lane-wise model.
module tb_exec_vect_seq;

    localparam int N = 24;
    localparam int M = 6;
    localparam int P = 2;
    localparam int G = M / P;
    localparam int W = M * N;
`ifdef EXEC_VECT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] rd1 = '0, rd2 = '0, rd3 = '0;
    logic [W-1:0] forward1 = '0, forward2 = '0, forward3 = '0;
    logic [N-1:0] imm = '0;
    logic [3:0]   alu_control = '0;
    logic         imm_src = 1'b0, fa = 1'b0, fb = 1'b0, fc = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [W-1:0] rd3_out;

    exec_vect_seq #(.N(N), .M(M), .P(P)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rd1(rd1), .rd2(rd2), .rd3(rd3),
        .forward1(forward1), .forward2(forward2), .forward3(forward3),
        .imm(imm), .alu_control(alu_control),
        .imm_src(imm_src), .fa(fa), .fb(fb), .fc(fc),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .rd3_out(rd3_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] rd1, rd2, rd3, f1, f2, f3;
        logic [N-1:0] imm;
        logic [3:0]   alu;
        logic         imm_src, fa, fb, fc;
        logic [W-1:0] exp_res;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [W-1:0] rep(input logic [N-1:0] v);
        return {M{v}};
    endfunction

    function automatic logic [W-1:0] seq(input int start, input int step);
        logic [W-1:0] r;
        for (int i = 0; i < M; i++) r[i*N +: N] = N'(start + i * step);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] r;
        for (int i = 0; i < M; i++) r[i*N +: N] = N'($urandom);
        return r;
    endfunction

    // Reference model: per-lane arithmetic on 64-bit integers, masked to N bits
    function automatic logic [W-1:0] model_res(input vec_t v);
        logic [W-1:0] o1, o2, r;
        longint unsigned a, b, y, maxv;
        int sh;
        maxv = (64'd1 << N) - 1;
        o1 = v.fa ? v.f1 : v.rd1;
        case ({v.fb, v.imm_src})
            2'b00:   o2 = v.rd2;
            2'b01:   o2 = rep(v.imm);
            2'b10:   o2 = v.f2;
            default: o2 = '0;
        endcase
        r = '0;
        for (int i = 0; i < M; i++) begin
            a  = 64'(o1[i*N +: N]);
            b  = 64'(o2[i*N +: N]);
            sh = int'(b % 32);
            case (v.alu)
                4'd0: begin y = a + b; if (SAT && y > maxv) y = maxv; end
                4'd1: y = (SAT && a < b) ? 64'd0 : a - b;
                4'd2: y = a & b;
                4'd3: y = a | b;
                4'd4: y = a ^ b;
                4'd5: y = (sh >= N) ? 64'd0 : a << sh;
                4'd6: y = (sh >= N) ? 64'd0 : a >> sh;
                4'd7: y = a * b;
                4'd8: y = b;
                4'd9: y = (a < b) ? a : b;
                default: y = 64'd0;
            endcase
            r[i*N +: N] = N'(y & maxv);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] exp_rd3(input vec_t v);
        return v.fc ? v.f3 : v.rd3;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_inputs(input vec_t v);
        rd1 = v.rd1; rd2 = v.rd2; rd3 = v.rd3;
        forward1 = v.f1; forward2 = v.f2; forward3 = v.f3;
        imm = v.imm; alu_control = v.alu;
        imm_src = v.imm_src; fa = v.fa; fb = v.fb; fc = v.fc;
    endtask

    task automatic scramble();
        rd1 = rnd_vec(); rd2 = rnd_vec(); rd3 = rnd_vec();
        forward1 = rnd_vec(); forward2 = rnd_vec(); forward3 = rnd_vec();
        imm = N'($urandom); alu_control = 4'($urandom);
        imm_src = 1'($urandom); fa = 1'($urandom); fb = 1'($urandom); fc = 1'($urandom);
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge
    task automatic accept(input vec_t v);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin @(negedge clk); k++; end
        chk("in_ready_before_accept", W'(in_ready), W'(1));
        apply_inputs(v);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int hold);
        int lat;
        accept(v);
        wait_done(lat);
        chk({tag, "_latency"}, W'(lat), W'(G));
        repeat (hold) @(negedge clk);
        chk({tag, "_valid"}, W'(out_valid), W'(1));
        chk({tag, "_result"}, result, v.exp_res);
        chk({tag, "_rd3"}, rd3_out, exp_rd3(v));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_back_idle"}, W'(in_ready), W'(1));
    endtask

    vec_t tbl[14];
    vec_t b, v;
    logic [W-1:0] e;
    int lat, seen;

    initial begin
        // reset
        repeat (2) @(negedge clk);
        chk("rst_result", result, '0);
        chk("rst_rd3", rd3_out, '0);
        chk("rst_valid", W'(out_valid), W'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", W'(in_ready), W'(1));

        // directed table
        b = '{default: '0};
        for (int i = 0; i < 14; i++) tbl[i] = b;
        tbl[0].alu = 4'd0; tbl[0].rd1 = seq(1, 1); tbl[0].rd2 = rep(24'd10);
        tbl[0].rd3 = rep(24'h123456); tbl[0].exp_res = seq(11, 1);
        tbl[1].alu = 4'd1; tbl[1].fa = 1'b1; tbl[1].f1 = rep(24'd5); tbl[1].rd1 = rep(24'd9);
        tbl[1].imm_src = 1'b1; tbl[1].imm = 24'd7;
        tbl[1].exp_res = SAT ? rep(24'd0) : rep(24'hFFFFFE);
        tbl[2].alu = 4'd0; tbl[2].rd1 = rep(24'hFFFFFF); tbl[2].rd2 = rep(24'd1);
        tbl[2].exp_res = SAT ? rep(24'hFFFFFF) : rep(24'd0);
        tbl[3] = tbl[2]; tbl[3].fb = 1'b1; tbl[3].imm_src = 1'b1; tbl[3].f2 = rep(24'd3);
        tbl[3].exp_res = rep(24'hFFFFFF);
        tbl[4].alu = 4'd5; tbl[4].rd1 = seq(1, 3); tbl[4].imm_src = 1'b1; tbl[4].imm = 24'd24;
        tbl[4].exp_res = '0;
        tbl[5].alu = 4'd5; tbl[5].rd1 = rep(24'd1); tbl[5].imm_src = 1'b1; tbl[5].imm = 24'd23;
        tbl[5].exp_res = rep(24'h800000);
        tbl[6].alu = 4'd6; tbl[6].rd1 = rep(24'h800000); tbl[6].rd2 = rep(24'd23);
        tbl[6].exp_res = rep(24'd1);
        tbl[7].alu = 4'd7; tbl[7].rd1 = rep(24'd3); tbl[7].rd2 = rep(24'h555555);
        tbl[7].exp_res = rep(24'hFFFFFF);
        tbl[8].alu = 4'd8; tbl[8].fb = 1'b1; tbl[8].f2 = seq(100, 7);
        tbl[8].fc = 1'b1; tbl[8].f3 = seq(50, 1); tbl[8].rd3 = rep(24'd1);
        tbl[8].exp_res = seq(100, 7);
        tbl[9].alu = 4'd9; tbl[9].rd1 = seq(5, 1); tbl[9].rd2 = rep(24'd7);
        tbl[9].exp_res = {24'd7, 24'd7, 24'd7, 24'd7, 24'd6, 24'd5};
        tbl[10].alu = 4'd12; tbl[10].rd1 = seq(9, 2); tbl[10].rd2 = rep(24'd4);
        tbl[10].exp_res = '0;
        tbl[11].alu = 4'd2; tbl[11].rd1 = rep(24'hF0F0F0); tbl[11].rd2 = rep(24'hFF00FF);
        tbl[11].exp_res = rep(24'hF000F0);
        tbl[12] = tbl[11]; tbl[12].alu = 4'd4; tbl[12].exp_res = rep(24'h0FF00F);
        tbl[13] = tbl[11]; tbl[13].alu = 4'd3; tbl[13].exp_res = rep(24'hFFF0FF);

        for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("tbl%0d", i), 0);

        // DONE held with out_ready low for 5 cycles
        v = tbl[0]; v.fc = 1'b1; v.f3 = rep(24'hABCDEF);
        accept(v);
        wait_done(lat);
        chk("hold_latency", W'(lat), W'(G));
        for (int c = 0; c < 5; c++) begin
            chk("hold_valid", W'(out_valid), W'(1));
            chk("hold_result", result, seq(11, 1));
            chk("hold_rd3", rd3_out, rep(24'hABCDEF));
            chk("hold_in_ready", W'(in_ready), W'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold_release_ready", W'(in_ready), W'(1));
        chk("hold_release_valid", W'(out_valid), W'(0));

        // async reset during the second BUSY cycle
        accept(tbl[7]);
        @(negedge clk);
        e = seq(11, 1);
        e[0 +: 2*N] = {2{24'hFFFFFF}};
        chk("rst_mid_partial", result, e);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_result", result, '0);
        chk("rst_mid_valid", W'(out_valid), W'(0));
        chk("rst_mid_rd3", rd3_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(tbl[0], "after_rst", 1);

        // flush in BUSY with in_valid asserted at the flush edge
        accept(tbl[2]);
        flush = 1'b1;
        apply_inputs(tbl[9]);
        in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_in_ready", W'(in_ready), W'(1));
        chk("flush_valid", W'(out_valid), W'(0));
        chk("flush_stale_result", result, seq(11, 1));
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid || !in_ready) seen++;
            @(negedge clk);
        end
        chk("flush_stays_idle", W'(seen), W'(0));

        // flush and out_ready together in DONE
        accept(tbl[13]);
        wait_done(lat);
        chk("flush_done_latency", W'(lat), W'(G));
        flush = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        chk("flush_done_valid", W'(out_valid), W'(0));
        chk("flush_done_ready", W'(in_ready), W'(1));
        chk("flush_done_result", result, rep(24'hFFF0FF));

        // randomized requests against the model
        for (int i = 0; i < 40; i++) begin
            v.rd1 = rnd_vec(); v.rd2 = rnd_vec(); v.rd3 = rnd_vec();
            v.f1 = rnd_vec(); v.f2 = rnd_vec(); v.f3 = rnd_vec();
            v.imm = N'($urandom);
            v.alu = 4'($urandom_range(0, 15));
            v.imm_src = 1'($urandom); v.fa = 1'($urandom);
            v.fb = 1'($urandom); v.fc = 1'($urandom);
            v.exp_res = model_res(v);
            run_vec(v, $sformatf("rnd%0d_op%0d", i, v.alu), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
